// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory subsystem: arbiter state, grant owner
// and the latched downstream transaction.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_txn_t;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating busy-cycle counter; raises a sticky expired flag once a granted
// transaction has waited TIMEOUT_CYCLES cycles without a completion.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  input  logic done,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_expired;
  logic          w_tick;

  assign w_tick  = busy && !done && !clear;
  assign expired = r_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      if (clear)
        r_cnt <= '0;
      else if (w_tick && r_cnt != CW'(TIMEOUT_CYCLES))
        r_cnt <= r_cnt + CW'(1);
      // Only reset clears the flag; a late completion leaves it set.
      if (w_tick && r_cnt == CW'(TIMEOUT_CYCLES - 1))
        r_expired <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port with
// round-robin tie-break and a non-aborting timeout watchdog.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        timeout
);

  arb_state_t r_state, w_next;
  arb_grant_t r_last_grant;
  mem_txn_t   r_txn;
  logic       w_grant_i, w_grant_d, w_busy, w_i_req, w_d_req;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;
  assign w_busy  = (r_state == I_BUSY) || (r_state == D_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
    end else begin
      r_state <= w_next;
      if (w_busy && mem_resp)
        r_last_grant <= (r_state == I_BUSY) ? GRANT_I : GRANT_D;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          w_grant_d = (r_last_grant == GRANT_I);
          w_grant_i = (r_last_grant == GRANT_D);
        end else begin
          w_grant_i = w_i_req;
          w_grant_d = w_d_req;
        end
        if (w_grant_i)      w_next = I_BUSY;
        else if (w_grant_d) w_next = D_BUSY;
      end
      I_BUSY, D_BUSY: if (mem_resp) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Requester inputs are sampled only at grant; mid-transaction changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_txn <= '0;
    else if (w_grant_i)
      r_txn <= '{addr: i_address, wdata: 32'h0, be: 4'hF, we: 1'b0};
    else if (w_grant_d)
      r_txn <= '{addr: d_address, wdata: d_wdata, be: d_byte_enable, we: d_write};
  end

  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'h0;
    mem_address     = 32'h0;
    mem_wdata       = 32'h0;
    if (w_busy) begin
      mem_read        = !r_txn.we;
      mem_write       = r_txn.we;
      mem_byte_enable = r_txn.be;
      mem_address     = r_txn.addr;
      mem_wdata       = r_txn.wdata;
    end
    i_resp  = mem_resp && (r_state == I_BUSY);
    d_resp  = mem_resp && (r_state == D_BUSY);
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
  end

  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_grant_i | w_grant_d),
    .busy    (w_busy),
    .done    (mem_resp),
    .expired (timeout)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  logic        clk = 1'b0, rst = 1'b0;
  logic        i_read, d_read, d_write, mem_resp;
  logic [31:0] i_address, d_address, d_wdata, mem_rdata;
  logic [3:0]  d_byte_enable;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write, timeout;
  logic [3:0]  mem_byte_enable;

  int checks = 0, failures = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_byte_enable = 0; d_address = 0; d_wdata = 0; mem_resp = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    checks++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp, d_resp, timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rd=%b wr=%b be=%h a=%h wd=%h ir=%b dr=%b to=%b exp all zero",
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp, d_resp, timeout);
    end
    mem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ifetch();
    do_reset();
    i_read = 1; i_address = 32'h60;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin failures++; $display("FAIL ifetch_t0 mem_read got=%b exp=0", mem_read); end
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h60, 32'h0}) begin
      failures++;
      $display("FAIL ifetch_t1 got rd=%b wr=%b be=%h a=%h wd=%h exp rd=1 wr=0 be=f a=60 wd=0",
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_read, i_resp} !== 2'b10) begin failures++; $display("FAIL ifetch_wait got rd=%b ir=%b exp rd=1 ir=0", mem_read, i_resp); end
    @(negedge clk);
    mem_resp = 1; mem_rdata = 32'h13;
    #1;
    checks++;
    if ({i_resp, d_resp, i_rdata} !== {1'b1, 1'b0, 32'h13}) begin
      failures++;
      $display("FAIL ifetch_resp got ir=%b dr=%b rdata=%h exp ir=1 dr=0 rdata=13", i_resp, d_resp, i_rdata);
    end
    i_read = 0;
    @(negedge clk);
    mem_resp = 0;
    #1;
    checks++;
    if ({mem_read, i_resp} !== 2'b00) begin failures++; $display("FAIL ifetch_done got rd=%b ir=%b exp 0 0", mem_read, i_resp); end
  endtask

  task automatic test_dwrite();
    do_reset();
    d_write = 1; d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !== {1'b0, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL dwrite_bus got rd=%b wr=%b be=%h a=%h wd=%h exp rd=0 wr=1 be=3 a=100 wd=deadbeef",
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata);
    end
    @(negedge clk);
    mem_resp = 1;
    #1;
    checks++;
    if ({d_resp, i_resp} !== 2'b10) begin failures++; $display("FAIL dwrite_resp got dr=%b ir=%b exp dr=1 ir=0", d_resp, i_resp); end
    d_write = 0;
    @(negedge clk);
    mem_resp = 0;
    #1;
    checks++;
    if ({mem_write, mem_address, d_resp} !== '0) begin
      failures++;
      $display("FAIL dwrite_idle got wr=%b a=%h dr=%b exp all zero", mem_write, mem_address, d_resp);
    end
  endtask

  task automatic test_alternate();
    bit order[$];
    do_reset();
    i_read = 1; i_address = 32'h11; d_read = 1; d_address = 32'h22;
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      @(negedge clk);
      mem_resp = 0;
      if (mem_read) begin
        mem_resp = 1;
        #1;
        if (d_resp) order.push_back(1'b1);
        else if (i_resp) order.push_back(1'b0);
      end
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (order.size() != 6) begin failures++; $display("FAIL alt_count got=%0d exp=6", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] !== ((k % 2) == 0)) begin
        failures++;
        $display("FAIL alt_order idx=%0d got=%s exp=%s", k, order[k] ? "D" : "I", (k % 2 == 0) ? "D" : "I");
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    d_write = 1; d_address = 32'h200; d_wdata = 32'h5A5A_0001; d_byte_enable = 4'hF;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) begin d_write = 0; d_address = 32'hFFFF_0000; end
      checks++;
      if ({mem_write, mem_address, timeout} !== {1'b1, 32'h200, (n >= 9)}) begin
        failures++;
        $display("FAIL timeout_cycle%0d got wr=%b a=%h to=%b exp wr=1 a=200 to=%b",
                 n, mem_write, mem_address, timeout, (n >= 9));
      end
    end
    @(negedge clk);
    mem_resp = 1;
    #1;
    checks++;
    if ({d_resp, timeout} !== 2'b11) begin failures++; $display("FAIL timeout_resp got dr=%b to=%b exp 1 1", d_resp, timeout); end
    @(negedge clk);
    mem_resp = 0;
    checks++;
    if ({mem_write, timeout} !== 2'b01) begin failures++; $display("FAIL timeout_sticky got wr=%b to=%b exp wr=0 to=1", mem_write, timeout); end
  endtask

  task automatic test_reset_mid();
    d_write = 1; d_address = 32'h300; d_wdata = 32'h1234; d_byte_enable = 4'hC;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin failures++; $display("FAIL rstmid_busy got wr=%b exp 1", mem_write); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_write, mem_read, mem_address, timeout} !== '0) begin
      failures++;
      $display("FAIL rstmid_async got wr=%b rd=%b a=%h to=%b exp all zero", mem_write, mem_read, mem_address, timeout);
    end
    d_write = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_resp = 1;
    #1;
    checks++;
    if ({d_resp, i_resp} !== 2'b00) begin failures++; $display("FAIL rstmid_late_resp got dr=%b ir=%b exp 0 0", d_resp, i_resp); end
    @(negedge clk);
    mem_resp = 0;
    checks++;
    if ({mem_write, mem_read} !== 2'b00) begin failures++; $display("FAIL rstmid_idle got wr=%b rd=%b exp 0 0", mem_write, mem_read); end
  endtask

  // Model: a pending request per requester; when the port is free the
  // pending one wins, or on contention the one not served last time.
  task automatic test_random();
    bit          i_pend = 0, d_pend = 0, eb = 0, srv = 0, last = 0, resp, g;
    logic [31:0] e_addr = 0, e_wdata = 0;
    logic [3:0]  e_be = 0;
    bit          e_we = 0;
    int          wait_cnt = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, timeout} !==
          {eb && !e_we, eb && e_we, eb ? e_be : 4'h0, eb ? e_addr : 32'h0, eb ? e_wdata : 32'h0, 1'b0}) begin
        failures++;
        $display("FAIL rand_bus cyc=%0d got rd=%b wr=%b be=%h a=%h wd=%h to=%b exp rd=%b wr=%b be=%h a=%h wd=%h to=0",
                 cyc, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, timeout,
                 eb && !e_we, eb && e_we, eb ? e_be : 4'h0, eb ? e_addr : 32'h0, eb ? e_wdata : 32'h0);
      end
      resp = 0;
      if (eb) begin
        if (wait_cnt == 0) resp = 1; else wait_cnt--;
      end else resp = ($urandom_range(0, 7) == 0);
      mem_resp = resp; mem_rdata = $urandom;
      #1;
      checks++;
      if ({i_resp, d_resp} !== ((eb && resp) ? (srv ? 2'b01 : 2'b10) : 2'b00)) begin
        failures++;
        $display("FAIL rand_resp cyc=%0d got ir=%b dr=%b exp %b", cyc, i_resp, d_resp,
                 (eb && resp) ? (srv ? 2'b01 : 2'b10) : 2'b00);
      end
      checks++;
      if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin
        failures++;
        $display("FAIL rand_rdata cyc=%0d got i=%h d=%h exp %h", cyc, i_rdata, d_rdata, mem_rdata);
      end
      if (eb && resp) begin
        if (srv) begin d_pend = 0; d_read = 0; d_write = 0; end
        else begin i_pend = 0; i_read = 0; end
        last = srv;
      end else if (eb && $urandom_range(0, 3) == 0) begin
        if (srv) begin d_address = $urandom; d_wdata = $urandom; d_byte_enable = 4'($urandom); end
        else i_address = $urandom;
      end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_read = 1; i_address = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        int op = $urandom_range(0, 2);
        d_pend = 1; d_read = (op != 1); d_write = (op != 0);
        d_address = $urandom; d_wdata = $urandom; d_byte_enable = 4'($urandom);
      end
      if (eb && resp) eb = 0;
      else if (!eb && (i_pend || d_pend)) begin
        g = (i_pend && d_pend) ? !last : d_pend;
        srv = g; eb = 1; wait_cnt = $urandom_range(0, 4);
        if (g) begin e_addr = d_address; e_wdata = d_wdata; e_be = d_byte_enable; e_we = d_write; end
        else begin e_addr = i_address; e_wdata = 32'h0; e_be = 4'hF; e_we = 1'b0; end
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_dwrite();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning cycles a granted transaction may wait for mem_resp before timeout asserts.
REQ-002 SHALL use one clock and an asynchronous active-low reset.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_read  input  1  instruction-fetch read request, held until i_resp.
REQ-006 i_address  input  32  instruction-fetch address.
REQ-007 i_rdata  output  32  instruction-fetch read data.
REQ-008 i_resp  output  1  one-cycle completion pulse to fetch requester.
REQ-009 d_read  input  1  data read request, held until d_resp.
REQ-010 d_write  input  1  data write request, held until d_resp.
REQ-011 d_byte_enable  input  4  data write byte lanes.
REQ-012 d_address  input  32  data address.
REQ-013 d_wdata  input  32  data write data.
REQ-014 d_rdata  output  32  data read data.
REQ-015 d_resp  output  1  one-cycle completion pulse to data requester.
REQ-016 mem_read  output  1  downstream read strobe.
REQ-017 mem_write  output  1  downstream write strobe.
REQ-018 mem_byte_enable  output  4  downstream byte lanes.
REQ-019 mem_address  output  32  downstream address.
REQ-020 mem_wdata  output  32  downstream write data.
REQ-021 mem_resp  input  1  downstream completion pulse.
REQ-022 mem_rdata  input  32  downstream read data, valid with mem_resp.
REQ-023 timeout  output  1  sticky flag: granted transaction exceeded TIMEOUT_CYCLES.

Function
REQ-024 SHALL implement FSM with states IDLE, I_BUSY, D_BUSY.
REQ-025 IDLE: i_read only -> I_BUSY; d_read|d_write only -> D_BUSY; both pending -> the requester not in last_grant; none -> stay IDLE.
REQ-026 On grant, SHALL latch address, wdata, byte_enable and op into internal registers and drive the mem_* outputs only from those registers.
REQ-027 Latency: request visible in IDLE at cycle t -> mem_read/mem_write asserted at cycle t+1.
REQ-028 I_BUSY: mem_read=1, mem_write=0, mem_byte_enable=4'hF, mem_wdata=0.
REQ-029 D_BUSY: d_write=1 -> mem_write=1, mem_read=0; d_read alone -> mem_read=1; d_read and d_write together -> treated as write.
REQ-030 Outside BUSY states: mem_read=0, mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0.
REQ-031 i_rdata and d_rdata SHALL both equal mem_rdata combinationally at all times.
REQ-032 i_resp = mem_resp while in I_BUSY, else 0; d_resp = mem_resp while in D_BUSY, else 0 (zero-cycle pass-through).
REQ-033 On mem_resp in a BUSY state: return to IDLE next cycle, update last_grant to the served requester.
REQ-034 mem_resp in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-035 Requester inputs changing or dropping mid-transaction SHALL not alter the latched transaction; the resp pulse is still delivered.
REQ-036 Watchdog counter SHALL clear on grant, increment each BUSY cycle without mem_resp, and saturate; on reaching TIMEOUT_CYCLES set timeout=1.
REQ-037 timeout SHALL not abort the transaction; FSM keeps waiting for mem_resp; only reset clears timeout.

Reset
REQ-038 rst=0 SHALL immediately force state IDLE, all mem_* outputs 0, i_resp=0, d_resp=0, timeout=0, counter 0, latched registers 0.
REQ-039 Reset value of last_grant SHALL be instruction, so first contention grants data.
REQ-040 Reset mid-transaction SHALL abandon it; a late mem_resp after release is ignored per REQ-034.

Structure
REQ-041 arb_state_t (IDLE, I_BUSY, D_BUSY) and arb_grant_t (GRANT_I, GRANT_D) SHALL live in the shared rv32i_types package.
REQ-042 Watchdog counter SHALL be the single sub-module mem_watchdog (inputs clear, busy, done; output expired).

Verification
REQ-043 i_read=1, i_address=0x60; mem_resp after 3 cycles with mem_rdata=0x00000013 -> mem_read at t+1, mem_address=0x60, byte_enable=4'hF, i_resp one cycle, i_rdata=0x13, d_resp=0.
REQ-044 d_write=1, d_address=0x100, d_wdata=0xDEADBEEF, d_byte_enable=4'b0011 -> mem_write=1 with those values, d_resp on mem_resp, returns to IDLE.
REQ-045 i_read and d_read asserted same cycle from reset, held continuously -> D served first, I second, then alternate D/I on every subsequent contention.
REQ-046 TIMEOUT_CYCLES=8, grant with mem_resp withheld -> timeout=1 after 8 BUSY cycles, stays 1 after later mem_resp, FSM completes normally.
REQ-047 rst=0 asserted in D_BUSY between clock edges -> mem_write and mem_read drop to 0 before the next edge; mem_resp pulse after release yields no d_resp.
